// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch/data) arbiter onto a single shared memory with timeout
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req, if_addr          instruction fetch request (held until if_valid) and PC
//   dm_rd, dm_wr             data read/write requests (held until dm_valid)
//   dm_addr, dm_wdata        data address and store data
//   mem_ready, mem_rdata     single-cycle completion strobe and read data from memory
//   mem_addr, mem_wdata      registered command to memory
//   mem_rd, mem_wr           registered memory strobes
//   if_instr, if_valid       fetched word and 1-cycle valid pulse
//   dm_rdata, dm_valid       load data and 1-cycle done pulse (also for stores)
//   stall                    combinational pipeline freeze
//   arb_state                FSM state encoding
//   bus_err                  sticky timeout flag

module mem_port_arbiter #(
    parameter int TIMEOUT    = 16,
    parameter int MAX_DM_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        stall,
    output logic [2:0]  arb_state,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        IF_ACC  = 3'b001,
        DM_ACC  = 3'b010,
        IF_DONE = 3'b011,
        DM_DONE = 3'b100,
        ERR     = 3'b101
    } state_t;

    localparam int               RUN_W     = $clog2(MAX_DM_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_DM_RUN);
    localparam logic [4:0]       WAIT_LAST = 5'(TIMEOUT - 1);

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic [4:0]       wait_cnt;

    logic dm_req;
    logic run_full;
    logic grant_dm;
    logic grant_if;

    // Data normally wins; once MAX_DM_RUN data grants have starved a
    // waiting fetch, the fetch gets exactly one turn.
    always_comb begin
        dm_req   = dm_rd | dm_wr;
        run_full = if_req && (run_cnt >= RUN_MAX);
        grant_dm = dm_req && !run_full;
        grant_if = if_req && !grant_dm;
    end

    assign arb_state = state;

    // Gated by rst so every output reads 0 while the block is held in reset.
    assign stall = rst & ((if_req & ~if_valid) | ((dm_rd | dm_wr) & ~dm_valid));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            run_cnt   <= '0;
            wait_cnt  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            if_instr  <= '0;
            if_valid  <= 1'b0;
            dm_rdata  <= '0;
            dm_valid  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state     <= DM_ACC;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_wr    <= dm_wr;
                        mem_rd    <= dm_rd & ~dm_wr;   // write wins if both asked
                        wait_cnt  <= '0;
                        // grant_dm with if_req high implies run_cnt < RUN_MAX,
                        // so the increment saturates at RUN_MAX by construction.
                        if (if_req) begin
                            run_cnt <= run_cnt + 1'b1;
                        end else begin
                            run_cnt <= '0;
                        end
                    end else if (grant_if) begin
                        state    <= IF_ACC;
                        mem_addr <= if_addr;
                        mem_rd   <= 1'b1;
                        mem_wr   <= 1'b0;
                        wait_cnt <= '0;
                        run_cnt  <= '0;
                    end else begin
                        // No grant means no request at all, so if_req is low.
                        run_cnt <= '0;
                    end
                end

                IF_ACC, DM_ACC: begin
                    if (mem_ready) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (state == IF_ACC) begin
                            if_instr <= mem_rdata;
                            if_valid <= 1'b1;
                            state    <= IF_DONE;
                        end else begin
                            dm_rdata <= mem_rdata;
                            dm_valid <= 1'b1;
                            state    <= DM_DONE;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // This is the TIMEOUT-th cycle without ready: give up
                        // and report the pending requester with zero data.
                        wait_cnt <= wait_cnt + 5'd1;
                        mem_rd   <= 1'b0;
                        mem_wr   <= 1'b0;
                        bus_err  <= 1'b1;
                        state    <= ERR;
                        if (state == IF_ACC) begin
                            if_instr <= '0;
                            if_valid <= 1'b1;
                        end else begin
                            dm_rdata <= '0;
                            dm_valid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 5'd1;
                    end
                end

                IF_DONE, DM_DONE, ERR: begin
                    if_valid <= 1'b0;
                    dm_valid <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - transaction-model bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int TIMEOUT    = 16;
    localparam int MAX_DM_RUN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic        dm_rd = 1'b0;
    logic        dm_wr = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_addr, mem_wdata, if_instr, dm_rdata;
    logic        mem_rd, mem_wr, if_valid, dm_valid, stall, bus_err;
    logic [2:0]  arb_state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int resp_delay = 0;
    int strobe_cnt = 0;
    bit stray = 1'b0;
    bit keep_dm = 1'b0;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .MAX_DM_RUN(MAX_DM_RUN)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .if_instr(if_instr), .if_valid(if_valid),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .stall(stall), .arb_state(arb_state), .bus_err(bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: phase 0 = no transaction, 1 = command outstanding,
    // 2 = result being reported for one cycle.
    int          m_phase = 0;
    bit          m_is_if = 1'b0;
    bit          m_timed_out = 1'b0;
    int          m_waited = 0;
    int          m_run = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_if_instr = '0, m_dm_rdata = '0;
    bit          m_rd = 1'b0, m_wr = 1'b0, m_if_v = 1'b0, m_dm_v = 1'b0, m_err = 1'b0;

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C02_0004;
        return a * 32'd3 + 32'h1234_5678;
    endfunction

    function automatic logic [2:0] exp_state();
        if (m_phase == 0) return 3'd0;
        if (m_phase == 1) return m_is_if ? 3'd1 : 3'd2;
        if (m_timed_out) return 3'd5;
        return m_is_if ? 3'd3 : 3'd4;
    endfunction

    task automatic model_finish(input logic [31:0] data, input bit to);
        m_rd = 1'b0;
        m_wr = 1'b0;
        m_timed_out = to;
        if (to) m_err = 1'b1;
        if (m_is_if) begin m_if_instr = data; m_if_v = 1'b1; end
        else begin m_dm_rdata = data; m_dm_v = 1'b1; end
        m_phase = 2;
    endtask

    task automatic model_update();
        if (!rst) begin
            m_phase = 0; m_is_if = 0; m_timed_out = 0; m_waited = 0; m_run = 0;
            m_addr = '0; m_wdata = '0; m_if_instr = '0; m_dm_rdata = '0;
            m_rd = 0; m_wr = 0; m_if_v = 0; m_dm_v = 0; m_err = 0;
            return;
        end
        if (m_phase == 2) begin
            m_if_v = 0; m_dm_v = 0; m_phase = 0;
        end else if (m_phase == 1) begin
            if (mem_ready) model_finish(mem_rdata, 1'b0);
            else begin
                m_waited++;
                if (m_waited == TIMEOUT) model_finish(32'h0, 1'b1);
            end
        end else begin
            if ((dm_rd || dm_wr) && !(if_req && m_run >= MAX_DM_RUN)) begin
                m_is_if = 0; m_addr = dm_addr; m_wdata = dm_wdata;
                m_wr = dm_wr; m_rd = dm_rd && !dm_wr;
                m_phase = 1; m_waited = 0;
                m_run = if_req ? ((m_run + 1 > MAX_DM_RUN) ? MAX_DM_RUN : m_run + 1) : 0;
            end else if (if_req) begin
                m_is_if = 1; m_addr = if_addr; m_rd = 1; m_wr = 0;
                m_phase = 1; m_waited = 0; m_run = 0;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_update();
    end

    // Per-cycle compare, then the memory responder for the next edge.
    initial forever begin
        @(negedge clk);
        check("arb_state", {29'b0, arb_state}, {29'b0, exp_state()});
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("mem_rd", {31'b0, mem_rd}, {31'b0, m_rd});
        check("mem_wr", {31'b0, mem_wr}, {31'b0, m_wr});
        check("if_valid", {31'b0, if_valid}, {31'b0, m_if_v});
        check("dm_valid", {31'b0, dm_valid}, {31'b0, m_dm_v});
        check("if_instr", if_instr, m_if_instr);
        check("dm_rdata", dm_rdata, m_dm_rdata);
        check("bus_err", {31'b0, bus_err}, {31'b0, m_err});
        check("stall", {31'b0, stall},
              {31'b0, rst && ((if_req && !m_if_v) || ((dm_rd || dm_wr) && !m_dm_v))});
        if (mem_rd || mem_wr) begin
            mem_ready = (resp_delay >= 0) && (strobe_cnt == resp_delay);
            strobe_cnt++;
        end else begin
            mem_ready = stray;
            stray = 1'b0;
            strobe_cnt = 0;
        end
        mem_rdata = mem_ready ? rdata_for(mem_addr) : 32'h0BAD_F00D;
    end

    task automatic step();
        @(negedge clk);
        #1;
        if (if_valid) if_req = 1'b0;
        if (dm_valid) begin
            if (keep_dm) dm_addr = dm_addr + 32'h4;
            else begin dm_rd = 1'b0; dm_wr = 1'b0; end
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (arb_state == 3'd0 && !if_req && !dm_rd && !dm_wr) ok = 1'b1;
        end
        check(name, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  n_edge;
        int  dm_cyc;
        int  if_cyc;
        int  cnt;
        bit  found;

        rst = 1'b0;
        repeat (2) step();
        check("reset_state", {29'b0, arb_state}, 32'd0);
        rst = 1'b1;
        step();

        // Fetch at minimum latency, with a stray ready beforehand.
        stray = 1'b1;
        step();
        step();
        check("s1_idle_after_stray", {29'b0, arb_state}, 32'd0);
        resp_delay = 0;
        if_addr = 32'h40;
        if_req = 1'b1;
        n_edge = cyc + 1;
        step();
        check("s1_if_acc", {29'b0, arb_state}, 32'd1);
        check("s1_mem_addr", mem_addr, 32'h40);
        check("s1_mem_rd", {31'b0, mem_rd}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (if_valid) found = 1'b1; else step();
        end
        check("s1_valid_seen", {31'b0, found}, 32'd1);
        check("s1_latency", cyc - n_edge, 32'd1);
        check("s1_instr", if_instr, 32'h8C02_0004);
        step();
        check("s1_stall_after", {31'b0, stall}, 32'd0);
        check("s1_valid_one_cycle", {31'b0, if_valid}, 32'd0);

        // Simultaneous fetch and load: data first, fetch 3 cycles later.
        if_addr = 32'h80; if_req = 1'b1;
        dm_addr = 32'h300; dm_rd = 1'b1;
        step();
        check("s2_dm_first", {29'b0, arb_state}, 32'd2);
        dm_cyc = -1; if_cyc = -1;
        for (int i = 0; i < 30 && if_cyc < 0; i++) begin
            if (dm_valid && dm_cyc < 0) dm_cyc = cyc;
            if (if_valid) if_cyc = cyc;
            step();
        end
        check("s2_both_seen", {31'b0, (dm_cyc >= 0 && if_cyc >= 0)}, 32'd1);
        check("s2_order_gap", if_cyc - dm_cyc, 32'd3);
        wait_idle("s2_idle");

        // Starvation limit: exactly MAX_DM_RUN data grants before the fetch.
        rst = 1'b0; step(); rst = 1'b1;
        keep_dm = 1'b1;
        dm_addr = 32'h400; dm_rd = 1'b1;
        if_addr = 32'h500; if_req = 1'b1;
        cnt = 0; found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (dm_valid) cnt++;
            if (if_valid) found = 1'b1;
        end
        check("s3_fetch_seen", {31'b0, found}, 32'd1);
        check("s3_dm_run", cnt, 32'd4);
        keep_dm = 1'b0;
        wait_idle("s3_idle");

        // Read+write together is a write; command held while waiting.
        resp_delay = 3;
        dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_rd = 1'b1; dm_wr = 1'b1;
        step();
        check("s4_mem_wr", {31'b0, mem_wr}, 32'd1);
        check("s4_mem_rd", {31'b0, mem_rd}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 20 && arb_state == 3'd2; i++) begin
            cnt++;
            check("s4_addr_stable", mem_addr, 32'h100);
            check("s4_wdata_stable", mem_wdata, 32'hDEAD_BEEF);
            step();
        end
        check("s4_acc_cycles", cnt, 32'd4);
        check("s4_done_state", {29'b0, arb_state}, 32'd4);
        wait_idle("s4_idle");

        // No ready at all: timeout into ERR with zero data, sticky bus_err.
        resp_delay = -1;
        if_addr = 32'h200; if_req = 1'b1;
        step();
        cnt = 0;
        for (int i = 0; i < 40 && arb_state == 3'd1; i++) begin
            cnt++;
            step();
        end
        check("s5_wait_cycles", cnt, 32'd16);
        check("s5_err_state", {29'b0, arb_state}, 32'd5);
        check("s5_err_valid", {31'b0, if_valid}, 32'd1);
        check("s5_err_data", if_instr, 32'd0);
        check("s5_bus_err", {31'b0, bus_err}, 32'd1);
        step();
        check("s5_back_idle", {29'b0, arb_state}, 32'd0);
        check("s5_bus_err_held", {31'b0, bus_err}, 32'd1);

        // Reset in the middle of a data access.
        dm_addr = 32'h600; dm_rd = 1'b1;
        step();
        step();
        check("s6_in_dm_acc", {29'b0, arb_state}, 32'd2);
        rst = 1'b0;
        #1;
        check("s6_rst_state", {29'b0, arb_state}, 32'd0);
        check("s6_rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        check("s6_rst_mem_addr", mem_addr, 32'd0);
        check("s6_rst_stall", {31'b0, stall}, 32'd0);
        check("s6_rst_bus_err", {31'b0, bus_err}, 32'd0);
        dm_rd = 1'b0;
        resp_delay = 0;
        step();
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dm_valid) cnt++;
        end
        check("s6_no_valid_after", cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The parameter TIMEOUT SHALL default to 16 and give the cycles to wait for mem_ready before an access is declared failed.
REQ-002 The parameter MAX_DM_RUN SHALL default to 4 and give the consecutive data grants allowed while a fetch is pending.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-005 The port if_req SHALL be an input, 1 bit wide, and is the instruction-fetch request, held until if_valid.
REQ-006 The port if_addr SHALL be an input, 32 bits wide, and is the fetch address (PC).
REQ-007 The ports dm_rd and dm_wr SHALL be inputs, 1 bit wide each, and are the data read and write requests, held until dm_valid.
REQ-008 The ports dm_addr and dm_wdata SHALL be inputs, 32 bits wide each, and are the data address and write data.
REQ-009 The port mem_ready SHALL be an input, 1 bit wide, and is the single-cycle completion strobe from the shared memory.
REQ-010 The port mem_rdata SHALL be an input, 32 bits wide, and is the memory read data, valid with mem_ready.
REQ-011 The ports mem_addr and mem_wdata SHALL be outputs, 32 bits wide each, and carry the registered command to memory.
REQ-012 The ports mem_rd and mem_wr SHALL be outputs, 1 bit wide each, and carry the registered memory strobes.
REQ-013 The port if_instr SHALL be an output, 32 bits wide, with if_valid as a 1-bit output: the fetched word and a 1-cycle valid pulse.
REQ-014 The port dm_rdata SHALL be an output, 32 bits wide, with dm_valid as a 1-bit output: the load data and a 1-cycle done pulse (also pulsed for stores).
REQ-015 The port stall SHALL be an output, 1 bit wide, and is the combinational pipeline freeze.
REQ-016 The port arb_state SHALL be an output, 3 bits wide, and is the FSM state encoding.
REQ-017 The port bus_err SHALL be an output, 1 bit wide, and is a sticky timeout flag.

Function
REQ-018 The FSM states SHALL be IDLE=000, IF_ACC=001, DM_ACC=010, IF_DONE=011, DM_DONE=100, ERR=101.
REQ-019 In IDLE with any request, the block SHALL grant data over fetch, unless the count of consecutive data grants with if_req high has reached MAX_DM_RUN, in which case it SHALL grant fetch once.
REQ-020 On entering IF_ACC the block SHALL register mem_addr=if_addr and mem_rd=1 in the same edge.
REQ-021 On entering DM_ACC the block SHALL register mem_addr=dm_addr, mem_wdata=dm_wdata, and mem_wr=dm_wr or mem_rd=dm_rd.
REQ-022 If dm_rd and dm_wr are both high, the block SHALL perform a write only.
REQ-023 The mem_addr, mem_wdata, mem_rd and mem_wr outputs SHALL be held stable throughout the ACC states.
REQ-024 On mem_ready in an ACC state, the block SHALL clear the strobes, capture mem_rdata into if_instr or dm_rdata, and move to IF_DONE or DM_DONE.
REQ-025 In IF_DONE or DM_DONE the block SHALL pulse if_valid or dm_valid for exactly one cycle, then return to IDLE.
REQ-026 The minimum latency SHALL be: request at edge N, strobe from N+1, mem_ready at N+1 gives valid during cycle N+2.
REQ-027 Back-to-back requests SHALL therefore cost a minimum of 3 cycles each.
REQ-028 A 5-bit wait counter SHALL reset on entry to each ACC state and increment per cycle without mem_ready.
REQ-029 When the wait counter reaches TIMEOUT, the block SHALL clear the strobes, set bus_err, and enter ERR.
REQ-030 In ERR the block SHALL pulse the pending valid once with data 0, then go to IDLE; bus_err SHALL stay set until reset.
REQ-031 The data-run counter SHALL increment on each data grant while if_req=1, saturate at MAX_DM_RUN, and clear on any fetch grant or when if_req=0 in IDLE.
REQ-032 A mem_ready seen outside the ACC states SHALL be ignored.
REQ-033 The stall output SHALL equal (if_req & ~if_valid) | ((dm_rd|dm_wr) & ~dm_valid).
REQ-034 Request deassertion mid-access SHALL NOT abort the access; the result SHALL still be delivered.

Reset
REQ-035 While rst=0 the block SHALL be in IDLE with every output 0, including bus_err, and with the run and wait counters cleared.
REQ-036 A reset asserted mid-access SHALL drop the strobes immediately (asynchronously), discard the transaction, and produce no valid pulse after release.

Verification
REQ-037 The bench SHALL cover: if_req=1, if_addr=0x40, mem_ready one cycle after mem_rd, mem_rdata=0x8C020004 -> if_valid pulse with if_instr=0x8C020004 at N+2, and stall low the cycle after.
REQ-038 The bench SHALL cover: if_req and dm_rd raised together, both held -> DM_ACC first, then IF_ACC; dm_valid precedes if_valid.
REQ-039 The bench SHALL cover: if_req held with data requests continuously reasserted -> a fetch grant after exactly 4 data grants.
REQ-040 The bench SHALL cover: dm_wr=dm_rd=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> mem_wr=1, mem_rd=0, and mem_addr and mem_wdata stable until mem_ready.
REQ-041 The bench SHALL cover: mem_ready never asserted -> ERR after 16 wait cycles, bus_err=1, a valid pulse with data 0, then IDLE, with bus_err held.
REQ-042 The bench SHALL cover: rst low during DM_ACC -> all outputs 0 immediately, and no dm_valid after release.
